// File: rtl/cond_unit_if.sv
// cond_unit_if
// Groups the decoder/ALU signals that feed the conditional-execution stage
// together with the gated strobes and debug state it produces.
//   Inputs to the stage : Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
//                         CondLatch, InstrDone
//   Outputs of the stage: PCSrc, RegWrite, MemWrite, CondExDelayed, Flags,
//                         ExecCount, SkipCount
// The slave modport is used by cond_unit; the master modport by whatever
// drives it (decoder/ALU side, or a testbench).
interface cond_unit_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       Cond;
    logic [3:0]       ALUFlags;
    logic [1:0]       FlagW;
    logic             PCS;
    logic             RegW;
    logic             MemW;
    logic             NoWrite;
    logic             CondLatch;
    logic             InstrDone;
    logic             PCSrc;
    logic             RegWrite;
    logic             MemWrite;
    logic             CondExDelayed;
    logic [3:0]       Flags;
    logic [CNT_W-1:0] ExecCount;
    logic [CNT_W-1:0] SkipCount;

    modport slave (
        input  Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
               CondLatch, InstrDone,
        output PCSrc, RegWrite, MemWrite, CondExDelayed, Flags,
               ExecCount, SkipCount
    );

    modport master (
        output Cond, ALUFlags, FlagW, PCS, RegW, MemW, NoWrite,
               CondLatch, InstrDone,
        input  PCSrc, RegWrite, MemWrite, CondExDelayed, Flags,
               ExecCount, SkipCount
    );
endinterface

// File: rtl/cond_unit.sv
// cond_unit
// Conditional-execution stage placed after the ALU. Holds the NZCV flag
// register, evaluates the ARM condition field against it, gates the PC,
// register-file and memory write strobes, latches the condition result for
// the multicycle datapath and counts executed/skipped instructions.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-low reset
//   bus   - cond_unit_if.slave carrying condition field, ALU flags, flag
//           write enables, decoder write requests, latch/retire pulses and
//           the gated strobes, flag register and counters
// The CNT_W parameter must match the CNT_W of the connected interface.
module cond_unit #(
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        reset,
    cond_unit_if.slave  bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [3:0]       flags_q;
    logic [3:0]       flags_d;
    logic             condExDelayed_q;
    logic             condExDelayed_d;
    logic [CNT_W-1:0] execCount_q;
    logic [CNT_W-1:0] execCount_d;
    logic [CNT_W-1:0] skipCount_q;
    logic [CNT_W-1:0] skipCount_d;
    logic             condEx;
    logic             flagN;
    logic             flagZ;
    logic             flagC;
    logic             flagV;

    assign {flagN, flagZ, flagC, flagV} = flags_q;

    // Condition check uses the registered flags only, so a flag-setting
    // instruction is judged against the flags that existed before it.
    // Code 1111 is treated as always-execute like AL.
    always_comb begin
        condEx = 1'b1;
        case (bus.Cond)
            4'b0000: condEx = flagZ;
            4'b0001: condEx = ~flagZ;
            4'b0010: condEx = flagC;
            4'b0011: condEx = ~flagC;
            4'b0100: condEx = flagN;
            4'b0101: condEx = ~flagN;
            4'b0110: condEx = flagV;
            4'b0111: condEx = ~flagV;
            4'b1000: condEx = flagC & ~flagZ;
            4'b1001: condEx = ~flagC | flagZ;
            4'b1010: condEx = (flagN == flagV);
            4'b1011: condEx = (flagN != flagV);
            4'b1100: condEx = ~flagZ & (flagN == flagV);
            4'b1101: condEx = flagZ | (flagN != flagV);
            default: condEx = 1'b1;
        endcase
    end

    // Gated write strobes; compare instructions never write the register file.
    assign bus.PCSrc         = bus.PCS & condEx;
    assign bus.RegWrite      = bus.RegW & ~bus.NoWrite & condEx;
    assign bus.MemWrite      = bus.MemW & condEx;
    assign bus.Flags         = flags_q;
    assign bus.CondExDelayed = condExDelayed_q;
    assign bus.ExecCount     = execCount_q;
    assign bus.SkipCount     = skipCount_q;

    // Next-state for flags, latched condition and the debug counters.
    // The counters look at the pre-edge latched condition, so a CondLatch in
    // the same cycle as InstrDone only affects the next retirement.
    always_comb begin
        flags_d         = flags_q;
        condExDelayed_d = condExDelayed_q;
        execCount_d     = execCount_q;
        skipCount_d     = skipCount_q;
        if (bus.FlagW[1] & condEx) begin
            flags_d[3:2] = bus.ALUFlags[3:2];
        end
        if (bus.FlagW[0] & condEx) begin
            flags_d[1:0] = bus.ALUFlags[1:0];
        end
        if (bus.CondLatch) begin
            condExDelayed_d = condEx;
        end
        if (bus.InstrDone) begin
            if (condExDelayed_q) begin
                if (execCount_q != CNT_MAX) begin
                    execCount_d = execCount_q + CNT_ONE;
                end
            end else begin
                if (skipCount_q != CNT_MAX) begin
                    skipCount_d = skipCount_q + CNT_ONE;
                end
            end
        end
    end

    // State register; reset wins over any pending flag update or count.
    always_ff @(posedge clk) begin
        if (!reset) begin
            flags_q         <= 4'b0000;
            condExDelayed_q <= 1'b0;
            execCount_q     <= '0;
            skipCount_q     <= '0;
        end else begin
            flags_q         <= flags_d;
            condExDelayed_q <= condExDelayed_d;
            execCount_q     <= execCount_d;
            skipCount_q     <= skipCount_d;
        end
    end

endmodule

// File: tb/tb_cond_unit.sv
// tb_cond_unit
// Drives two cond_unit instances (CNT_W=16 and CNT_W=3) with identical
// stimulus and checks them against a behavioural model of the flag register,
// condition table, latched condition and saturating counters.
module tb_cond_unit;

    logic       clk;
    logic       rst;
    logic [3:0] cond;
    logic [3:0] aluFlags;
    logic [1:0] flagW;
    logic       pcs;
    logic       regW;
    logic       memW;
    logic       noWrite;
    logic       condLatch;
    logic       instrDone;

    int errors = 0;
    int checks = 0;

    // Model state
    logic [3:0] mFlags;
    bit         mCed;
    int         mExec16;
    int         mSkip16;
    int         mExec3;
    int         mSkip3;

    cond_unit_if #(.CNT_W(16)) bus16 ();
    cond_unit_if #(.CNT_W(3))  bus3 ();

    cond_unit #(.CNT_W(16)) dut16 (.clk(clk), .reset(rst), .bus(bus16));
    cond_unit #(.CNT_W(3))  dut3  (.clk(clk), .reset(rst), .bus(bus3));

    assign bus16.Cond      = cond;
    assign bus16.ALUFlags  = aluFlags;
    assign bus16.FlagW     = flagW;
    assign bus16.PCS       = pcs;
    assign bus16.RegW      = regW;
    assign bus16.MemW      = memW;
    assign bus16.NoWrite   = noWrite;
    assign bus16.CondLatch = condLatch;
    assign bus16.InstrDone = instrDone;
    assign bus3.Cond       = cond;
    assign bus3.ALUFlags   = aluFlags;
    assign bus3.FlagW      = flagW;
    assign bus3.PCS        = pcs;
    assign bus3.RegW       = regW;
    assign bus3.MemW       = memW;
    assign bus3.NoWrite    = noWrite;
    assign bus3.CondLatch  = condLatch;
    assign bus3.InstrDone  = instrDone;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Condition table written directly from the ARM mnemonics.
    function automatic bit condModel(input logic [3:0] c, input logic [3:0] f);
        bit n;
        bit z;
        bit cf;
        bit v;
        n  = f[3];
        z  = f[2];
        cf = f[1];
        v  = f[0];
        case (c)
            4'd0:    return z;
            4'd1:    return !z;
            4'd2:    return cf;
            4'd3:    return !cf;
            4'd4:    return n;
            4'd5:    return !n;
            4'd6:    return v;
            4'd7:    return !v;
            4'd8:    return cf && !z;
            4'd9:    return !cf || z;
            4'd10:   return n == v;
            4'd11:   return n != v;
            4'd12:   return !z && (n == v);
            4'd13:   return z || (n != v);
            default: return 1'b1;
        endcase
    endfunction

    // Drive every input in one call; reset is handled separately.
    task automatic applyStimulus(input logic [3:0] c, input logic [3:0] alu,
                                 input logic [1:0] fw, input logic p,
                                 input logic rw, input logic mw,
                                 input logic nw, input logic cl,
                                 input logic done);
        cond      = c;
        aluFlags  = alu;
        flagW     = fw;
        pcs       = p;
        regW      = rw;
        memW      = mw;
        noWrite   = nw;
        condLatch = cl;
        instrDone = done;
    endtask

    // Advance one clock: compute the model's next state from the inputs
    // held before the edge, then step past the edge.
    task automatic cycle();
        bit         ce;
        logic [3:0] nf;
        ce = condModel(cond, mFlags);
        nf = mFlags;
        if (flagW[1] && ce) nf[3:2] = aluFlags[3:2];
        if (flagW[0] && ce) nf[1:0] = aluFlags[1:0];
        @(posedge clk);
        if (!rst) begin
            mFlags  = 4'b0000;
            mCed    = 1'b0;
            mExec16 = 0;
            mSkip16 = 0;
            mExec3  = 0;
            mSkip3  = 0;
        end else begin
            if (instrDone) begin
                if (mCed) begin
                    mExec16 = (mExec16 < 65535) ? mExec16 + 1 : mExec16;
                    mExec3  = (mExec3 < 7) ? mExec3 + 1 : mExec3;
                end else begin
                    mSkip16 = (mSkip16 < 65535) ? mSkip16 + 1 : mSkip16;
                    mSkip3  = (mSkip3 < 7) ? mSkip3 + 1 : mSkip3;
                end
            end
            if (condLatch) mCed = ce;
            mFlags = nf;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        applyStimulus(4'b1110, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        cycle();
        cycle();
        checks++;
        if (bus16.Flags !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL reset_flags got=%b exp=0000", bus16.Flags);
        end
        checks++;
        if (bus16.CondExDelayed !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_ced got=%b exp=0", bus16.CondExDelayed);
        end
        checks++;
        if (bus16.ExecCount !== 16'd0 || bus16.SkipCount !== 16'd0 ||
            bus3.ExecCount !== 3'd0 || bus3.SkipCount !== 3'd0) begin
            errors++;
            $display("[TB] FAIL reset_counts got=%0d/%0d/%0d/%0d exp=0", bus16.ExecCount,
                     bus16.SkipCount, bus3.ExecCount, bus3.SkipCount);
        end
        rst = 1'b1;
        applyStimulus(4'b0000, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (bus16.PCSrc !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_eq_pcsrc got=%b exp=0", bus16.PCSrc);
        end
    endtask

    task automatic test_flag_update();
        applyStimulus(4'b1110, 4'b0110, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        checks++;
        if (bus16.Flags !== 4'b0110) begin
            errors++;
            $display("[TB] FAIL flag_update got=%b exp=0110", bus16.Flags);
        end
        applyStimulus(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (bus16.RegWrite !== 1'b1) begin
            errors++;
            $display("[TB] FAIL eq_regwrite got=%b exp=1", bus16.RegWrite);
        end
        applyStimulus(4'b1000, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (bus16.PCSrc !== 1'b0) begin
            errors++;
            $display("[TB] FAIL hi_pcsrc got=%b exp=0", bus16.PCSrc);
        end
    endtask

    task automatic test_partial_update();
        applyStimulus(4'b1110, 4'b1001, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        checks++;
        if (bus16.Flags !== 4'b1010) begin
            errors++;
            $display("[TB] FAIL partial_update got=%b exp=1010", bus16.Flags);
        end
        applyStimulus(4'b1011, 4'b0000, 2'b00, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (bus16.PCSrc !== 1'b1) begin
            errors++;
            $display("[TB] FAIL lt_pcsrc got=%b exp=1", bus16.PCSrc);
        end
        applyStimulus(4'b1010, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        checks++;
        if (bus16.MemWrite !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ge_memwrite got=%b exp=0", bus16.MemWrite);
        end
    endtask

    task automatic test_failed_update();
        applyStimulus(4'b1110, 4'b0000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        applyStimulus(4'b0000, 4'b1111, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        checks++;
        if (bus16.Flags !== 4'b0000) begin
            errors++;
            $display("[TB] FAIL failed_cond_update got=%b exp=0000", bus16.Flags);
        end
        applyStimulus(4'b1110, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        checks++;
        if (bus16.RegWrite !== 1'b0) begin
            errors++;
            $display("[TB] FAIL nowrite_regwrite got=%b exp=0", bus16.RegWrite);
        end
    endtask

    task automatic test_counters();
        applyStimulus(4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle();
        applyStimulus(4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) cycle();
        checks++;
        if (bus16.ExecCount !== 16'd3) begin
            errors++;
            $display("[TB] FAIL exec_three got=%0d exp=3", bus16.ExecCount);
        end
        applyStimulus(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        cycle();
        checks++;
        if (bus16.ExecCount !== 16'd4 || bus16.SkipCount !== 16'd0 ||
            bus16.CondExDelayed !== 1'b0) begin
            errors++;
            $display("[TB] FAIL latch_and_done got=%0d/%0d/%b exp=4/0/0",
                     bus16.ExecCount, bus16.SkipCount, bus16.CondExDelayed);
        end
        applyStimulus(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        cycle();
        checks++;
        if (bus16.SkipCount !== 16'd1 || bus16.ExecCount !== 16'd4) begin
            errors++;
            $display("[TB] FAIL skip_one got=%0d/%0d exp=4/1", bus16.ExecCount,
                     bus16.SkipCount);
        end
    endtask

    task automatic test_saturation();
        rst = 1'b0;
        applyStimulus(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        cycle();
        rst = 1'b1;
        applyStimulus(4'b1110, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        cycle();
        applyStimulus(4'b1110, 4'b1010, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 9; i++) cycle();
        checks++;
        if (bus3.ExecCount !== 3'd7) begin
            errors++;
            $display("[TB] FAIL saturate_w3 got=%0d exp=7", bus3.ExecCount);
        end
        checks++;
        if (bus16.ExecCount !== 16'd9 || bus16.Flags !== 4'b1010) begin
            errors++;
            $display("[TB] FAIL no_saturate_w16 got=%0d/%b exp=9/1010",
                     bus16.ExecCount, bus16.Flags);
        end
        rst = 1'b0;
        applyStimulus(4'b1110, 4'b0101, 2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        cycle();
        rst = 1'b1;
        checks++;
        if (bus3.ExecCount !== 3'd0 || bus16.ExecCount !== 16'd0 ||
            bus16.Flags !== 4'b0000 || bus16.CondExDelayed !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midseq_reset got=%0d/%0d/%b/%b exp=0/0/0000/0",
                     bus3.ExecCount, bus16.ExecCount, bus16.Flags, bus16.CondExDelayed);
        end
    endtask

    task automatic test_random();
        bit ce;
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 31) != 0);
            applyStimulus(4'($urandom), 4'($urandom), 2'($urandom), 1'($urandom),
                          1'($urandom), 1'($urandom), 1'($urandom),
                          1'($urandom), ($urandom_range(0, 3) != 0));
            #1;
            ce = condModel(cond, mFlags);
            checks++;
            if (bus16.PCSrc !== (pcs & ce) || bus16.RegWrite !== (regW & !noWrite & ce) ||
                bus16.MemWrite !== (memW & ce)) begin
                errors++;
                $display("[TB] FAIL rand_strobes i=%0d got=%b%b%b exp=%b%b%b", i,
                         bus16.PCSrc, bus16.RegWrite, bus16.MemWrite,
                         pcs & ce, regW & !noWrite & ce, memW & ce);
            end
            cycle();
            checks++;
            if (bus16.Flags !== mFlags || bus16.CondExDelayed !== mCed ||
                bus3.Flags !== mFlags) begin
                errors++;
                $display("[TB] FAIL rand_state i=%0d got=%b/%b exp=%b/%b", i,
                         bus16.Flags, bus16.CondExDelayed, mFlags, mCed);
            end
            checks++;
            if (bus16.ExecCount !== 16'(mExec16) || bus16.SkipCount !== 16'(mSkip16) ||
                bus3.ExecCount !== 3'(mExec3) || bus3.SkipCount !== 3'(mSkip3)) begin
                errors++;
                $display("[TB] FAIL rand_counts i=%0d got=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d",
                         i, bus16.ExecCount, bus16.SkipCount, bus3.ExecCount,
                         bus3.SkipCount, mExec16, mSkip16, mExec3, mSkip3);
            end
        end
        rst = 1'b1;
    endtask

    initial begin
        rst     = 1'b0;
        mFlags  = 4'b0000;
        mCed    = 1'b0;
        mExec16 = 0;
        mSkip16 = 0;
        mExec3  = 0;
        mSkip3  = 0;
        applyStimulus(4'b0000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        test_reset();
        test_flag_update();
        test_partial_update();
        test_failed_update();
        test_counters();
        test_saturation();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cond_unit.md
Name: cond_unit

Overview:
- Conditional-execution stage that sits directly downstream of the 32-bit ALU and consumes its ALUFlags output.
- Holds the architectural NZCV flag register and evaluates the 4-bit ARM condition field against it.
- Gates the PC, register-file and memory write strobes with the condition result.
- For the multicycle datapath, latches the condition result across the instruction and keeps executed/skipped instruction counters for debug.

Parameters:
- CNT_W, 16, width of the executed/skipped instruction counters.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous active-low reset; reset=0 at a rising clk edge resets the block.
- Cond  input  4  instruction condition field, Instr[31:28].
- ALUFlags  input  4  {N,Z,C,V} from the ALU for the current operation.
- FlagW  input  2  [1] enables the N,Z update; [0] enables the C,V update.
- PCS  input  1  decoder request to write the PC.
- RegW  input  1  decoder request to write the register file.
- MemW  input  1  decoder request to write memory.
- NoWrite  input  1  compare instruction (CMP/CMN/TST/TEQ); suppresses the register write.
- CondLatch  input  1  capture the current condition result into CondExDelayed.
- InstrDone  input  1  one-cycle pulse marking instruction retirement.
- PCSrc  output  1  gated PC write.
- RegWrite  output  1  gated register-file write.
- MemWrite  output  1  gated memory write.
- CondExDelayed  output  1  latched condition result.
- Flags  output  4  current {N,Z,C,V} register.
- ExecCount  output  CNT_W  count of retired instructions whose condition passed.
- SkipCount  output  CNT_W  count of retired instructions whose condition failed.

Behaviour:
- Reset (reset=0 at posedge):
  - Flags=4'b0000, CondExDelayed=0, ExecCount=0, SkipCount=0.
  - Reset overrides every other input in that cycle.
  - Reset mid-instruction discards any pending flag update and any pending count.
- CondEx (internal, combinational) is computed from Cond and the *registered* Flags, never from ALUFlags:
  - 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C.
  - 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V.
  - 1000 HI C&!Z; 1001 LS !C|Z.
  - 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V).
  - 1110 AL 1; 1111 is treated as unconditional, CondEx=1.
- Gated outputs, combinational with zero latency:
  - PCSrc = PCS & CondEx.
  - RegWrite = RegW & !NoWrite & CondEx.
  - MemWrite = MemW & CondEx.
- Flag register, updated at posedge when reset=1:
  - If FlagW[1] & CondEx: Flags[3:2] <= ALUFlags[3:2].
  - If FlagW[0] & CondEx: Flags[1:0] <= ALUFlags[1:0].
  - Fields whose enable is low hold their value.
  - An update is visible on Flags and in CondEx one cycle later.
  - A flag-setting instruction is evaluated against the pre-update flags.
- CondExDelayed: loads CondEx at posedge when CondLatch=1, otherwise holds.
- Counters, updated at posedge when InstrDone=1:
  - If CondExDelayed=1, ExecCount increments; otherwise SkipCount increments.
  - The pre-edge value of CondExDelayed is used, so CondLatch and InstrDone in the same cycle count the old value.
  - Both counters saturate at 2^CNT_W-1 and never wrap.
- Simultaneous CondLatch, flag update and InstrDone in one cycle are all legal and independent; each uses pre-edge state.
- No X propagation: all outputs are defined from the first clock after reset.

Test Plan:
- Hold reset=0 for 2 cycles with ALUFlags=4'b1111, FlagW=2'b11 → Flags=0, CondExDelayed=0, counters 0. Then Cond=0000 → CondEx=0, so PCS=1 gives PCSrc=0.
- Cond=1110, FlagW=2'b11, ALUFlags=4'b0110 for one cycle → Flags=4'b0110 next cycle. Then Cond=0000 (EQ), RegW=1, NoWrite=0 → RegWrite=1; Cond=1000 (HI, C=1,Z=1) → PCS=1 gives PCSrc=0.
- Flags=4'b0110, Cond=1110, FlagW=2'b10, ALUFlags=4'b1001 → Flags=4'b1010 (C,V held). Then Cond=1011 (LT, N=1,V=0) → CondEx=1; Cond=1010 (GE) → MemW=1 gives MemWrite=0.
- Flags=4'b0000, Cond=0000 (fails), FlagW=2'b11, ALUFlags=4'b1111 → Flags stays 0000. Also RegW=1, NoWrite=1, Cond=1110 → RegWrite=0.
- Sequence: CondLatch with CondEx=1, then InstrDone ×3 → ExecCount=3. Then CondLatch and InstrDone in the same cycle with CondEx=0 → ExecCount=4, SkipCount=0. Next InstrDone → SkipCount=1.
- With CNT_W=3: 9 InstrDone pulses with CondExDelayed=1 → ExecCount saturates at 7. Assert reset=0 mid-sequence → ExecCount=0 next cycle and Flags=0.
